// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- byte-wide program memory read bus.
//   mem_addr  : byte address driven by the fetch unit
//   mem_rd    : one-cycle read strobe driven by the fetch unit
//   mem_rdata : read data returned by memory
//   mem_valid : mem_rdata is valid this cycle (any latency >= 1 cycle)
// Modports: master = fetch unit side, slave = memory side.
interface fetch_unit_if;
   logic [11:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        mem_valid;

   modport master (
      output mem_addr,
      output mem_rd,
      input  mem_rdata,
      input  mem_valid
   );

   modport slave (
      input  mem_addr,
      input  mem_rd,
      output mem_rdata,
      output mem_valid
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- fetches a 16-bit instruction as two byte reads (high byte at
// pc, low byte at pc+1) and owns the program counter.
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   mem             fetch_unit_if.master, program memory byte bus
//   fetch_req_i     start a fetch at pc (ignored while busy)
//   pc_inc_i        pc += 2   (IDLE only)
//   pc_skip_i       pc += 4   (IDLE only)
//   pc_load_i       pc = pc_load_addr_i (IDLE only, highest priority)
//   pc_load_addr_i  new pc value
//   instruction_o   last assembled instruction {high, low}
//   instr_valid_o   one-cycle pulse in DONE
//   busy_o          high in every state except IDLE
//   pc_o            current program counter
//   fetch_err_o     sticky misaligned-fetch flag
//
// Optional feature: define FETCH_ALIGN_ERR_EN to reject fetches at odd pc
// (fetch_err_o set until reset, no memory read issued). Without it, odd-pc
// fetches proceed normally and fetch_err_o stays 0.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | accept pc controls and fetch_req_i
// RD_HI   | mem_rd strobe, mem_addr = pc
// WAIT_HI | wait for mem_valid, capture high byte
// RD_LO   | mem_rd strobe, mem_addr = pc + 1
// WAIT_LO | wait for mem_valid, capture low byte
// DONE    | instruction updated, instr_valid_o pulse
module fetch_unit #(
   parameter logic [11:0] PC_RESET = 12'h200
) (
   input  logic                clk,
   input  logic                rst,
   fetch_unit_if.master        mem,
   input  logic                fetch_req_i,
   input  logic                pc_inc_i,
   input  logic                pc_skip_i,
   input  logic                pc_load_i,
   input  logic [11:0]         pc_load_addr_i,
   output logic [15:0]         instruction_o,
   output logic                instr_valid_o,
   output logic                busy_o,
   output logic [11:0]         pc_o,
   output logic                fetch_err_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_HI   = 3'd1,
      WAIT_HI = 3'd2,
      RD_LO   = 3'd3,
      WAIT_LO = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t      state_q;
   logic [11:0] pc_q;
   logic [11:0] pc_d;
   logic [11:0] mem_addr_q;
   logic        mem_rd_q;
   logic [7:0]  hi_q;
   logic [15:0] instruction_q;
   logic        instr_valid_q;
   logic        busy_q;
   logic        fetch_err_q;
   logic        misalign;

   // Candidate pc for this IDLE cycle; a fetch issued in the same cycle uses
   // it, so a jump plus fetch reads from the jump target.
   always_comb begin
      pc_d = pc_q;
      if (pc_load_i)
         pc_d = pc_load_addr_i;
      else if (pc_skip_i)
         pc_d = pc_q + 12'd4;
      else if (pc_inc_i)
         pc_d = pc_q + 12'd2;
   end

`ifdef FETCH_ALIGN_ERR_EN
   assign misalign = pc_d[0];
`else
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= PC_RESET;
         mem_addr_q    <= '0;
         mem_rd_q      <= 1'b0;
         hi_q          <= '0;
         instruction_q <= '0;
         instr_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         fetch_err_q   <= 1'b0;
      end else begin
         mem_rd_q      <= 1'b0;
         instr_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               pc_q <= pc_d;
               if (fetch_req_i) begin
                  if (misalign) begin
                     fetch_err_q <= 1'b1;
                  end else begin
                     state_q    <= RD_HI;
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= pc_d;
                     busy_q     <= 1'b1;
                  end
               end
            end
            RD_HI: state_q <= WAIT_HI;
            WAIT_HI: begin
               if (mem.mem_valid) begin
                  hi_q       <= mem.mem_rdata;
                  mem_rd_q   <= 1'b1;
                  // 12-bit add wraps 12'hFFF to 12'h000
                  mem_addr_q <= pc_q + 12'd1;
                  state_q    <= RD_LO;
               end
            end
            RD_LO: state_q <= WAIT_LO;
            WAIT_LO: begin
               if (mem.mem_valid) begin
                  instruction_q <= {hi_q, mem.mem_rdata};
                  instr_valid_q <= 1'b1;
                  state_q       <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_rd    = mem_rd_q;
   assign instruction_o = instruction_q;
   assign instr_valid_o = instr_valid_q;
   assign busy_o        = busy_q;
   assign pc_o          = pc_q;
   assign fetch_err_o   = fetch_err_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 12'h200, PC value loaded on reset (program start).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 fetch_req  input  1  start fetch of the 16-bit instruction at pc.
REQ-005 pc_inc  input  1  advance pc by 2.
REQ-006 pc_skip  input  1  advance pc by 4 (skip next instruction).
REQ-007 pc_load  input  1  load pc from pc_load_addr (JMP/CALL/RET/JMP_V0).
REQ-008 pc_load_addr  input  12  new pc value.
REQ-009 mem_addr  output  12  byte address to program memory.
REQ-010 mem_rd  output  1  one-cycle read strobe.
REQ-011 mem_rdata  input  8  read data, sampled when mem_valid=1.
REQ-012 mem_valid  input  1  read data valid, any latency >=1 cycle after mem_rd.
REQ-013 instruction  output  16  assembled instruction, {high byte, low byte}, feeds decode.
REQ-014 instr_valid  output  1  one-cycle pulse when instruction is updated.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 pc  output  12  current program counter.
REQ-017 fetch_err  output  1  misaligned-fetch flag (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, RD_HI, WAIT_HI, RD_LO, WAIT_LO, DONE.
REQ-019 IDLE -> RD_HI on fetch_req=1; RD_HI -> WAIT_HI unconditionally; WAIT_HI -> RD_LO on mem_valid=1; RD_LO -> WAIT_LO unconditionally; WAIT_LO -> DONE on mem_valid=1; DONE -> IDLE unconditionally.
REQ-020 mem_rd SHALL be 1 only in RD_HI (mem_addr=pc) and RD_LO (mem_addr=pc+1, modulo 4096).
REQ-021 mem_rdata SHALL be captured as high byte in WAIT_HI and as low byte in WAIT_LO; mem_valid in any other state SHALL be ignored.
REQ-022 instr_valid SHALL be 1 only in DONE; instruction SHALL hold its value until the next DONE.
REQ-023 With mem_valid one cycle after mem_rd, fetch_req sampled at edge N SHALL yield instr_valid during cycle N+5.
REQ-024 pc updates SHALL apply only in IDLE with priority pc_load > pc_skip > pc_inc; all pc controls are ignored while busy=1.
REQ-025 pc arithmetic SHALL be 12-bit modulo 4096 (12'hFFE + 4 = 12'h002).
REQ-026 fetch_req SHALL be ignored while busy=1.
REQ-027 fetch_req with a pc control in the same IDLE cycle: pc SHALL update and the fetch SHALL use the updated pc.
REQ-028 A fetch at pc=12'hFFF SHALL read high byte from 12'hFFF and low byte from 12'h000.

Reset
REQ-029 On rst=1: state=IDLE, pc=PC_RESET, instruction=16'h0000, instr_valid=0, mem_rd=0, mem_addr=0, busy=0, fetch_err=0.
REQ-030 rst asserted mid-fetch SHALL abort without instr_valid; a mem_valid arriving after reset SHALL be ignored.
REQ-031 rst SHALL take priority over every other input.

Configuration
REQ-032 Macro FETCH_ALIGN_ERR_EN: when defined, fetch_req in IDLE with pc[0]=1 SHALL set fetch_err=1, issue no mem_rd, stay in IDLE; fetch_err stays set until rst.
REQ-033 Without FETCH_ALIGN_ERR_EN, odd-pc fetches SHALL proceed normally and fetch_err SHALL be tied 0.

Verification
REQ-034 Reset, memory[0x200]=0x12, [0x201]=0x34, 1-cycle latency, fetch_req -> instr_valid 5 cycles later, instruction=16'h1234, pc=12'h200.
REQ-035 pc_load=1, pc_load_addr=12'h3A0 with pc_inc=1 and pc_skip=1 same cycle -> pc=12'h3A0.
REQ-036 pc=12'hFFE, pc_skip -> pc=12'h002; pc=12'hFFF fetch -> mem_addr sequence 12'hFFF, 12'h000.
REQ-037 mem_valid delayed 7 cycles per byte; fetch_req and pc_inc pulsed while busy -> single instr_valid, pc unchanged.
REQ-038 rst asserted in WAIT_LO, then stray mem_valid -> no instr_valid, instruction=16'h0000, pc=12'h200.
REQ-039 FETCH_ALIGN_ERR_EN defined, pc_load 12'h201, fetch_req -> fetch_err=1, mem_rd never asserted; undefined -> normal fetch from 12'h201/12'h202.
